conv_layer_mem: RTL
===================

Name: conv_layer_mem

Overview:
- Memory-side responder for the convolution engine's image/layer interface. It answers the engine's requests on that interface.
- It holds the grayscale image ROM, served on iaddr/idata.
- It holds five layer banks selected by csel: L0 kernel0/kernel1, L1 kernel0/kernel1, and L2 flatten. These are written via cwr and read via crd.
- It sequences the ready/busy start handshake. It also offers a debug read port so the bench can check results without poking arrays.

Parameters:
- DW, 20, data width of image and layer words.
- AW, 12, address width of iaddr/caddr_wr/caddr_rd.
- IMG_DEPTH, 4096, image words (64x64).
- L0_DEPTH, 4096, depth of each L0 bank.
- L1_DEPTH, 1024, depth of each L1 bank.
- L2_DEPTH, 2048, depth of the L2 flatten bank.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- ld_valid  in  1  image load strobe.
- ld_addr  in  AW  image load address.
- ld_data  in  DW  image load data.
- ld_last  in  1  marks the final load beat; qualified by ld_valid.
- ready  out  1  image loaded, engine may start.
- busy  in  1  engine busy.
- iaddr  in  AW  image read address.
- idata  out  DW  image read data.
- cwr  in  1  layer write enable.
- caddr_wr  in  AW  layer write address.
- cdata_wr  in  DW  layer write data.
- crd  in  1  layer read enable.
- caddr_rd  in  AW  layer read address.
- cdata_rd  out  DW  layer read data.
- csel  in  3  bank select: 001 L0k0, 010 L0k1, 011 L1k0, 100 L1k1, 101 L2.
- dbg_sel  in  3  debug bank select, same encoding as csel.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DW  debug read data.
- done  out  1  one-cycle pulse when the engine finishes.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values of all outputs are 0: ready, idata, cdata_rd, dbg_data, done, err. The FSM resets to LOAD. Memory contents are not cleared.
- FSM states:
  - LOAD: ld_valid writes img[ld_addr] <= ld_data. ld_valid&ld_last moves to RDY.
  - RDY: ready=1. When busy is sampled 1, ready drops the next cycle and the FSM moves to RUN.
  - RUN: ready=0. When busy is sampled 1->0 (busy was 1 in the previous cycle and is 0 now), done pulses 1 for the next cycle and the FSM moves to FIN.
  - FIN: ready=0. ld_valid moves back to LOAD; that same beat is written to the image.
- Image read: idata <= img[iaddr] every cycle, in any state. Latency is 1 cycle.
- Layer write: when cwr=1 and csel is valid, bank[csel][caddr_wr] <= cdata_wr.
- Layer read: when crd=1 and csel is valid, cdata_rd <= bank[csel][caddr_rd], latency 1. Otherwise cdata_rd holds its last value.
- cwr and crd in the same cycle to the same address: the read returns the old data (read-before-write).
- Invalid csel (000, 110, 111) with cwr or crd: the access is ignored, cdata_rd holds, and err is set.
- Address >= depth of the selected bank: the write is ignored; a read returns 0. Both set err.
- ld_valid outside LOAD/FIN: the beat is ignored and err is set.
- busy=1 seen in LOAD: err is set and the FSM stays in LOAD.
- err clears only on reset.
- Debug port: dbg_data <= bank[dbg_sel][dbg_addr], latency 1. An invalid select or out-of-range address returns 0. This port never sets err.
- Reset mid-operation (any state): the FSM returns to LOAD, and ready/done/err clear the next cycle. A done pulse is never emitted without a preceding RUN.

Optional Feature:
- LAYER_WR_CNT_EN defined:
  - Adds an output wr_cnt, 5x13 bits packed, with one counter per bank (L0k0 in the LSBs).
  - Each counter increments on every accepted cwr to its bank and saturates at 8191.
  - Counters clear on reset and on the LOAD->RDY transition.
- LAYER_WR_CNT_EN undefined: the port and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package conv_mem_pkg holds:
  - csel encodings as constants (SEL_L0K0=3'b001 ... SEL_L2=3'b101);
  - FSM state typedef (LOAD, RDY, RUN, FIN);
  - depth constants and DW/AW defaults.
- Sub-module conv_bank_ram: a single-port-write, dual-read-port synchronous RAM (functional read and debug read), parameterized by depth, with read-before-write.
- Instantiate conv_bank_ram 5 times plus once for the image.

Test Plan:
- Load img[k]=k for k=0..4095, with ld_last on k=4095 -> ready=1 the next cycle. iaddr=100 -> idata=100 one cycle later.
- Handshake: in RDY drive busy=1 -> ready=0 the next cycle. Hold busy 10 cycles, then drop it -> done=1 for exactly one cycle, FSM in FIN.
- Write: csel=011, caddr_wr=1023, cdata_wr=20'h0ABCD. Then crd with caddr_rd=1023 -> cdata_rd=20'h0ABCD after 1 cycle. dbg_sel=011 returns the same value.
- Same-cycle cwr+crd on csel=101, address 5 (old 20'h00001, new 20'h00002) -> cdata_rd=20'h00001. Next read -> 20'h00002.
- Error cases, each checked separately; each sets err and err stays high:
  - csel=011, caddr_wr=1024: bank unchanged.
  - csel=110 with crd: cdata_rd holds.
- Reset asserted during RUN with busy=1 -> ready=0, done=0, err=0, FSM in LOAD. Image contents are still readable via iaddr.

Source files
------------

// File: rtl/conv_mem_pkg.sv
// Shared constants, bank-select encodings and FSM state type for conv_layer_mem.
package conv_mem_pkg;
  localparam int DW_DEF        = 20;
  localparam int AW_DEF        = 12;
  localparam int IMG_DEPTH_DEF = 4096;
  localparam int L0_DEPTH_DEF  = 4096;
  localparam int L1_DEPTH_DEF  = 1024;
  localparam int L2_DEPTH_DEF  = 2048;
  localparam int NUM_BANKS     = 5;
  localparam int CNT_W         = 13;

  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RDY  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } fsm_state_t;
endpackage

// File: rtl/conv_bank_ram.sv
// Synchronous RAM: one write port, a functional read port and a debug read port,
// both reads returning pre-write data and zero for out-of-range addresses.
module conv_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic wr_ok_s, rd_ok_s, dbg_ok_s;

  assign wr_ok_s  = ({1'b0, waddr} < LIMIT);
  assign rd_ok_s  = ({1'b0, raddr} < LIMIT);
  assign dbg_ok_s = ({1'b0, dbg_addr} < LIMIT);

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && wr_ok_s) mem_r[waddr[IW-1:0]] <= wdata;
  end

  // Read registers; rdata holds when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= {DW{1'b0}};
      dbg_data <= {DW{1'b0}};
    end else begin
      if (re) rdata <= rd_ok_s ? mem_r[raddr[IW-1:0]] : {DW{1'b0}};
      dbg_data <= dbg_ok_s ? mem_r[dbg_addr[IW-1:0]] : {DW{1'b0}};
    end
  end
endmodule

// File: rtl/conv_layer_mem.sv
// Image ROM, five layer banks and start handshake for the convolution engine.
// Optional LAYER_WR_CNT_EN adds per-bank saturating write counters on wr_cnt.
module conv_layer_mem
  import conv_mem_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int IMG_DEPTH = IMG_DEPTH_DEF,
  parameter int L0_DEPTH  = L0_DEPTH_DEF,
  parameter int L1_DEPTH  = L1_DEPTH_DEF,
  parameter int L2_DEPTH  = L2_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic [2:0]    dbg_sel,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          done,
  output logic          err
`ifdef LAYER_WR_CNT_EN
  ,
  output logic [NUM_BANKS*CNT_W-1:0] wr_cnt
`endif
);
  localparam int BANK_DEPTH [NUM_BANKS] = '{L0_DEPTH, L0_DEPTH, L1_DEPTH, L1_DEPTH, L2_DEPTH};

  fsm_state_t           state_r;
  logic                 busy_q_r;
  logic [2:0]           rd_sel_r, dbg_sel_r;
  logic [AW:0]          sel_depth_s;
  logic                 sel_ok_s, wr_in_s, rd_in_s, err_set_s, img_we_s;
  logic [NUM_BANKS-1:0] bank_we_s, bank_re_s;
  logic [DW-1:0]        bank_rd_s  [NUM_BANKS];
  logic [DW-1:0]        bank_dbg_s [NUM_BANKS];
  logic [DW-1:0]        img_dbg_unused_s;

  // Decode selected bank depth and qualify layer accesses.
  always_comb begin
    case (csel)
      SEL_L0K0, SEL_L0K1: sel_depth_s = (AW+1)'(L0_DEPTH);
      SEL_L1K0, SEL_L1K1: sel_depth_s = (AW+1)'(L1_DEPTH);
      SEL_L2:             sel_depth_s = (AW+1)'(L2_DEPTH);
      default:            sel_depth_s = {(AW+1){1'b0}};
    endcase
    sel_ok_s = (sel_depth_s != {(AW+1){1'b0}});
    wr_in_s  = sel_ok_s && ({1'b0, caddr_wr} < sel_depth_s);
    rd_in_s  = sel_ok_s && ({1'b0, caddr_rd} < sel_depth_s);
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_we_s[i] = cwr && wr_in_s && (csel == 3'(i + 1));
      bank_re_s[i] = crd && sel_ok_s && (csel == 3'(i + 1));
    end
    img_we_s  = ld_valid && ((state_r == LOAD) || (state_r == FIN));
    err_set_s = ((cwr || crd) && !sel_ok_s) ||
                (cwr && sel_ok_s && !wr_in_s) ||
                (crd && sel_ok_s && !rd_in_s) ||
                (ld_valid && ((state_r == RDY) || (state_r == RUN))) ||
                (busy && (state_r == LOAD));
  end

  conv_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(AW)) u_img (
    .clk(clk), .reset(reset), .we(img_we_s), .waddr(ld_addr), .wdata(ld_data),
    .re(1'b1), .raddr(iaddr), .rdata(idata),
    .dbg_addr({AW{1'b0}}), .dbg_data(img_dbg_unused_s)
  );

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    conv_bank_ram #(.DEPTH(BANK_DEPTH[g]), .DW(DW), .AW(AW)) u_ram (
      .clk(clk), .reset(reset), .we(bank_we_s[g]), .waddr(caddr_wr), .wdata(cdata_wr),
      .re(bank_re_s[g]), .raddr(caddr_rd), .rdata(bank_rd_s[g]),
      .dbg_addr(dbg_addr), .dbg_data(bank_dbg_s[g])
    );
  end

  // Handshake FSM with registered ready/done and sticky err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= LOAD;
      ready     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy_q_r  <= 1'b0;
      rd_sel_r  <= 3'b000;
      dbg_sel_r <= 3'b000;
    end else begin
      busy_q_r  <= busy;
      done      <= 1'b0;
      dbg_sel_r <= dbg_sel;
      if (err_set_s) err <= 1'b1;
      if (crd && sel_ok_s) rd_sel_r <= csel;
      case (state_r)
        LOAD: if (!busy && ld_valid && ld_last) begin
          state_r <= RDY;
          ready   <= 1'b1;
        end
        RDY: if (busy) begin
          state_r <= RUN;
          ready   <= 1'b0;
        end
        RUN: if (busy_q_r && !busy) begin
          state_r <= FIN;
          done    <= 1'b1;
        end
        FIN: if (ld_valid) state_r <= LOAD;
        default: begin
          state_r <= LOAD;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Route the bank last read (or debug-selected) to the shared outputs.
  always_comb begin
    case (rd_sel_r)
      SEL_L0K0: cdata_rd = bank_rd_s[0];
      SEL_L0K1: cdata_rd = bank_rd_s[1];
      SEL_L1K0: cdata_rd = bank_rd_s[2];
      SEL_L1K1: cdata_rd = bank_rd_s[3];
      SEL_L2:   cdata_rd = bank_rd_s[4];
      default:  cdata_rd = {DW{1'b0}};
    endcase
    case (dbg_sel_r)
      SEL_L0K0: dbg_data = bank_dbg_s[0];
      SEL_L0K1: dbg_data = bank_dbg_s[1];
      SEL_L1K0: dbg_data = bank_dbg_s[2];
      SEL_L1K1: dbg_data = bank_dbg_s[3];
      SEL_L2:   dbg_data = bank_dbg_s[4];
      default:  dbg_data = {DW{1'b0}};
    endcase
  end

`ifdef LAYER_WR_CNT_EN
  logic             load_done_s;
  logic [CNT_W-1:0] wr_cnt_r [NUM_BANKS];

  assign load_done_s = (state_r == LOAD) && !busy && ld_valid && ld_last;

  // Saturating per-bank write counters, restarted when a new image completes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (reset || load_done_s) wr_cnt_r[i] <= {CNT_W{1'b0}};
      else if (bank_we_s[i] && (wr_cnt_r[i] != {CNT_W{1'b1}})) wr_cnt_r[i] <= wr_cnt_r[i] + 1'b1;
    end
  end

  // Pack counters, L0k0 in the LSBs.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) wr_cnt[i*CNT_W +: CNT_W] = wr_cnt_r[i];
  end
`endif
endmodule
